// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sumador_comp.sv
// rtl/sumador_comp.sv - single-bit full adder cell
module sumador_comp (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencing one full adder over WIDTH bits
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;

    sumador_comp u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the LSB computed first ends up at bit 0.
    assign sum_nxt = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_o     <= '0;
            cout_o    <= 1'b0;
            ovf_o     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a_i;
                        b_sh     <= b_i;
                        carry    <= cin_i;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= fa_cout;
                    if (cnt == CNT_LAST) begin
                        // On the last bit, carry still holds the carry into the MSB.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum_o     <= sum_nxt;
                        cout_o    <= fa_cout;
                        ovf_o     <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .ovf_o     (ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold);
        int           s;
        int           lat;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        s  = int'(a) + int'(b) + int'(c);
        es = W'(s);
        ec = s[W];
        eo = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);

        @(negedge clk);
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        cin_i    = c;
        check("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a_i      = W'($urandom);
        b_i      = W'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        check("sum", sum_o, es);
        check("cout", cout_o, ec);
        check("ovf", ovf_o, eo);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_i      = W'($urandom);
            b_i      = W'($urandom);
            cin_i    = 1'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum_o, es);
            check("hold_cout", cout_o, ec);
            check("hold_ovf", ovf_o, eo);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum_o, 0);
        check("rst_cout", cout_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 5);
        run_op(8'h03, 8'h04, 1'b0, 0);

        // Reset and in_valid together: operands must be dropped.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a_i      = 8'h55;
        b_i      = 8'h55;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_wins_ready", in_ready, 1);
        @(negedge clk);
        check("rst_wins_idle", in_ready, 1);

        // Abort on the 4th RUN cycle.
        in_valid = 1'b1;
        a_i      = 8'hC3;
        b_i      = 8'h3C;
        cin_i    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        run_op(8'h10, 8'h20, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences a single sumador_comp full-adder cell across WIDTH bits.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds one bit pair per clock through the full adder and holds the ripple carry in a flop.
- Returns the WIDTH-bit sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits between an operand source and a result consumer wherever area matters more than throughput.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.
- CNT_W, $clog2(WIDTH) (minimum 1), bit-counter width; derived, not overridden.

Ports:
- clk        input   1      single clock; every flop is rising-edge.
- rst        input   1      synchronous, active-high reset.
- in_valid   input   1      operand bundle valid.
- in_ready   output  1      controller can accept operands.
- a_i        input   WIDTH  operand A (unsigned or two's complement).
- b_i        input   WIDTH  operand B.
- cin_i      input   1      initial carry-in.
- out_valid  output  1      result valid.
- out_ready  input   1      consumer accepts result.
- sum_o      output  WIDTH  A + B + cin, modulo 2^WIDTH.
- cout_o     output  1      carry out of the MSB.
- ovf_o      output  1      signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum_o=0, cout_o=0, ovf_o=0. All internal shift registers, carry flop and counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh<=a_i, b_sh<=b_i, carry<=cin_i, cnt<=0; go to RUN.
- RUN (in_ready=0, out_valid=0), each cycle:
  - Full-adder inputs are a_sh[0], b_sh[0], carry.
  - a_sh and b_sh shift right by 1.
  - sum_sh shifts right with the adder sum entering at bit WIDTH-1.
  - carry<=cout.
  - When cnt==WIDTH-1: capture cmsb<=carry (the carry into the MSB) before the update; go to DONE.
  - Otherwise cnt<=cnt+1.
- DONE:
  - out_valid=1.
  - sum_o=sum_sh, cout_o=carry, ovf_o=cmsb^carry.
  - All three outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE. out_valid drops and in_ready rises in the next cycle.
- Latency: if the handshake is sampled at edge 0, out_valid is high from edge WIDTH+1 onward. Minimum issue interval is WIDTH+2 cycles.
- sum_o, cout_o and ovf_o are registered. Outside DONE they hold their last values and are don't-care; the bench checks them only while out_valid=1.
- in_valid outside IDLE is ignored; no queuing.
- WIDTH=1: exactly one RUN cycle; cmsb equals the loaded cin_i.
- Reset mid-RUN or mid-DONE: abort the operation. Next cycle is IDLE with reset values. No out_valid is produced for the aborted operation.
- Simultaneous rst and in_valid: reset wins and the operands are dropped.
- Counter never exceeds WIDTH-1; no wrap-around within an operation.

Decomposition:
- Package serial_add_pkg:
  - state typedef enum logic [1:0] {IDLE, RUN, DONE}.
  - Default-width constant DEF_WIDTH=8.
- Sub-module: reuse the existing sumador_comp (ports a, b, cin, sum, cout) as the single full-adder instance.
- FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan (WIDTH=8):
- 0x00+0x00, cin=0 -> sum_o=0x00, cout_o=0, ovf_o=0. out_valid rises exactly 9 cycles after the accept edge.
- 0xFF+0x01, cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0.
- 0x7F+0x01, cin=0 -> sum_o=0x80, cout_o=0, ovf_o=1. Also 0x80+0x80 -> sum_o=0x00, cout_o=1, ovf_o=1.
- 0xA5+0x5A, cin=1 -> sum_o=0x00, cout_o=1, ovf_o=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs stable, in_ready=0, new operands ignored. Then release out_ready -> IDLE; the next op 0x03+0x04 yields 0x07.
- Reset mid-op: assert rst on the 4th RUN cycle -> next cycle is IDLE with in_ready=1, out_valid=0 and never asserts for the aborted op. A following 0x10+0x20, cin=1 yields 0x31.
